// File: rtl/cpu_run_ctrl.sv
// Run/step/halt controller for the RV32I core: conditions the board run switch
// and step button, stretches the core reset, and gates the pipeline enable.

module cpu_run_ctrl_db #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_db,
    output logic o_db_q
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          s1, s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            o_db   <= 1'b0;
            o_db_q <= 1'b0;
        end else begin
            s1     <= i_raw;
            s2     <= s1;
            o_db_q <= o_db;
            // The debounced level only moves after s2 has disagreed for DEBOUNCE_CYCLES edges.
            if (s2 != o_db) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    o_db <= s2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module cpu_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RST_HOLD        = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_run_sw,
    input  logic        i_step_btn,
    input  logic        i_halt_req,
    output logic        o_cpu_rst_n,
    output logic        o_cpu_en,
    output logic        o_halted,
    output logic [31:0] o_en_cnt
);
    localparam int RW = $clog2(RST_HOLD + 1);

    typedef enum logic [1:0] {S_RESET, S_HALT, S_RUN, S_STEP} state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] rst_cnt;
    logic          halt_latch;
    logic          run_db, run_db_q, step_db, step_db_q;
    logic          step_pulse, run_fall;

    cpu_run_ctrl_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_raw  (i_run_sw),
        .o_db   (run_db),
        .o_db_q (run_db_q)
    );

    cpu_run_ctrl_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_raw  (i_step_btn),
        .o_db   (step_db),
        .o_db_q (step_db_q)
    );

    assign step_pulse = step_db & ~step_db_q;
    assign run_fall   = ~run_db & run_db_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_RESET;
            rst_cnt    <= '0;
            halt_latch <= 1'b0;
            o_en_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_RESET)
                rst_cnt <= rst_cnt + 1'b1;
            // Turning the switch off re-arms RUN after a core-requested halt.
            if (run_fall)
                halt_latch <= 1'b0;
            else if (state == S_RUN && i_halt_req)
                halt_latch <= 1'b1;
            if (o_cpu_en)
                o_en_cnt <= o_en_cnt + 32'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RESET: if (rst_cnt == RW'(RST_HOLD - 1)) state_nxt = S_HALT;
            S_HALT: begin
                if (run_db && !halt_latch) state_nxt = S_RUN;
                else if (step_pulse)       state_nxt = S_STEP;
            end
            S_RUN:   if (i_halt_req || !run_db) state_nxt = S_HALT;
            S_STEP:  state_nxt = S_HALT;
            default: state_nxt = S_RESET;
        endcase
    end

    assign o_cpu_rst_n = (state != S_RESET);
    assign o_cpu_en    = (state == S_RUN) || (state == S_STEP);
    assign o_halted    = (state == S_HALT);
endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/step/halt controller for the pipelined RV32I core on the FPGA board. It sits between the board switches and buttons and the core, and owns the core's reset and clock-enable. It debounces the run switch and step button, and stretches the core reset after a system reset. It then issues a continuous enable (RUN), a single-cycle enable per button press (STEP), or none (HALT). The core can request a sticky halt (e.g. on `ebreak` retire).

## Interface

**Parameters**
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before a debounced input changes. Must be ≥ 2.
- `RST_HOLD`, default 8: number of cycles `o_cpu_rst_n` stays low after `i_rst` deasserts. Must be ≥ 1.

**Ports**
- `i_clk`, input, 1: the single clock.
- `i_rst`, input, 1: asynchronous, active-high reset.
- `i_run_sw`, input, 1: raw run switch, asynchronous; 1 = free-run request.
- `i_step_btn`, input, 1: raw step button, asynchronous, active-high.
- `i_halt_req`, input, 1: synchronous halt request from the core; single-cycle or level.
- `o_cpu_rst_n`, output, 1: active-low reset to the core.
- `o_cpu_en`, output, 1: pipeline clock-enable.
- `o_halted`, output, 1: high while in HALT.
- `o_en_cnt`, output, 32: count of cycles with `o_cpu_en` = 1; wraps modulo 2^32.

## Operation

**Input conditioning**
- `i_run_sw` and `i_step_btn` each pass through a 2-flop synchronizer (`s2` is the second flop), then a debouncer with its own counter.
- Debouncer, evaluated per edge:
  - If `s2` ≠ `db`: when `cnt` = `DEBOUNCE_CYCLES`-1, then `db` ← `s2` and `cnt` ← 0; otherwise `cnt`++.
  - If `s2` = `db`: `cnt` ← 0.
  - Glitches shorter than `DEBOUNCE_CYCLES` therefore never reach `db`.
- `step_pulse` = `step_db` & ~`step_db_q`. This is the rising edge only, one cycle per press.
- `run_fall` = ~`run_db` & `run_db_q`.

**Halt latch**
- Set by `i_halt_req` = 1 while in RUN.
- Cleared by `run_fall`.
- While the latch is set, RUN cannot be entered. The user must turn the run switch off and on again.

**State machine (Moore)** — states RESET, HALT, RUN, STEP.
- **RESET**
  - `rst_cnt` increments each cycle.
  - When `rst_cnt` = `RST_HOLD`-1, go to HALT.
- **HALT**
  - If `run_db` = 1 and the halt latch is clear, go to RUN. This has priority; a simultaneous `step_pulse` is discarded.
  - Otherwise, if `step_pulse` = 1, go to STEP. Step is allowed even when the halt latch is set.
- **RUN**
  - If `i_halt_req` = 1 or `run_db` = 0, go to HALT.
  - `step_pulse` is ignored.
- **STEP**
  - Always go to HALT after one cycle.

**Output decode (from the state register)**
- `o_cpu_rst_n` = (state ≠ RESET).
- `o_cpu_en` = (state = RUN) or (state = STEP).
- `o_halted` = (state = HALT).
- `o_en_cnt` increments on every edge where `o_cpu_en` = 1.

**Reset**
- `i_rst` = 1, including mid-operation, asynchronously forces:
  - state = RESET and `rst_cnt` = 0;
  - all synchronizer, debouncer and edge registers = 0;
  - halt latch = 0 and `o_en_cnt` = 0.
- Output values during reset: `o_cpu_rst_n` = 0, `o_cpu_en` = 0, `o_halted` = 0, `o_en_cnt` = 0.

## Timing

- **Reset release:** `o_cpu_rst_n` rises exactly `RST_HOLD` edges after the first edge with `i_rst` = 0. `o_halted` rises on the same edge.
- **Step latency:** a raw press is first sampled at edge 0. `step_db` rises at edge `DEBOUNCE_CYCLES`+1. STEP is entered at edge `DEBOUNCE_CYCLES`+2. `o_cpu_en` is high for exactly one cycle.
- **Run latency:** `run_db` rises at edge `DEBOUNCE_CYCLES`+1. `o_cpu_en` rises at edge `DEBOUNCE_CYCLES`+2. Run-off has the symmetric latency.
- **Halt request:**
  - `o_cpu_en` stays high in the cycle where `i_halt_req` is sampled.
  - `o_cpu_en` falls on the next edge.
  - The core sees exactly one further enabled cycle after asserting the request.
- **Holding the step button:** produces one pulse per press, independent of how long the button is held.
- **`o_en_cnt` wrap:** 0xFFFFFFFF + 1 → 0x00000000, with no flag.

## Test plan

Use `DEBOUNCE_CYCLES` = 4 and `RST_HOLD` = 8.

1. **Reset release.** Release `i_rst` → `o_cpu_rst_n`=0 for 8 edges, then 1 with `o_halted`=1, `o_cpu_en`=0, `o_en_cnt`=0.
2. **Single step.** Press `i_step_btn` for 20 cycles → one `o_cpu_en` pulse, rising at edge 6 after the press; `o_en_cnt`=1; back in HALT.
3. **Glitch rejection.** Pulse `i_step_btn` high for 3 cycles → no `o_cpu_en`; `o_en_cnt` unchanged.
4. **Run and halt.**
   - Set `i_run_sw`=1 → continuous `o_cpu_en` from edge 6.
   - After 10 enabled cycles, pulse `i_halt_req` for 1 cycle → `o_cpu_en` falls on the next edge; `o_en_cnt`=11; `o_halted`=1.
   - `i_run_sw` still 1 → stays halted.
   - Toggle `i_run_sw` 0→1 with each level held ≥ 6 cycles → RUN resumes.
5. **Simultaneous events.**
   - In HALT, `run_db` and `step_pulse` rise on the same cycle → enter RUN; no separate step.
   - Step press during RUN → no extra effect.
6. **Reset mid-operation.** Assert `i_rst` mid-RUN with `o_en_cnt`=25 → outputs are immediately 0, 0, 0, 0; after release the reset-hold sequence repeats and the counter restarts at 0.
